// File: rtl/adc_scan_scheduler.sv
// Periodic ADC channel scanner: walks the set bits of a channel mask, issues one
// conversion per channel, and hands each result to a one-entry output buffer.
module adc_scan_scheduler #(
  parameter int ADDR_SETTLE    = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        enable_i,
  input  logic [7:0]  chan_mask_i,
  input  logic [15:0] period_i,
  input  logic        clear_status_i,
  output logic [2:0]  conv_addr_o,
  output logic        conv_start_o,
  input  logic        conv_done_i,
  input  logic [7:0]  conv_data_i,
  output logic        tx_valid_o,
  output logic [10:0] tx_data_o,
  input  logic        tx_ready_i,
  output logic        busy_o,
  output logic [2:0]  status_o
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, SETTLE, START, CONVERT} state_t;

  state_t        state_q, state_d;
  logic [15:0]   per_cnt_q, per_cnt_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [3:0]    set_cnt_q, set_cnt_d;
  logic [7:0]    scan_mask_q, scan_mask_d;
  logic [2:0]    addr_q, addr_d;
  logic          tx_valid_q, tx_valid_d;
  logic [10:0]   tx_data_q, tx_data_d;
  logic [2:0]    status_q, status_d;
  logic          tick, wr, to_hit;
  logic [3:0]    nxt;

  // Returns {found, index} of the lowest set bit at or above floor.
  function automatic logic [3:0] next_chan(input logic [7:0] mask, input logic [3:0] floor);
    logic [3:0] r;
    r = 4'b0;
    for (int i = 7; i >= 0; i--) begin
      if (mask[i] && (i >= int'(floor))) r = {1'b1, 3'(i)};
    end
    return r;
  endfunction

  assign tick      = enable_i && ((period_i <= 16'd1) || (per_cnt_q >= (period_i - 16'd1)));
  assign per_cnt_d = (!enable_i || tick) ? 16'd0 : per_cnt_q + 16'd1;

  always_comb begin
    state_d     = state_q;
    tmo_d       = tmo_q;
    set_cnt_d   = set_cnt_q;
    scan_mask_d = scan_mask_q;
    addr_d      = addr_q;
    wr          = 1'b0;
    to_hit      = 1'b0;
    nxt         = 4'b0;
    case (state_q)
      IDLE: begin
        if (tick && (chan_mask_i != 8'h00)) begin
          nxt         = next_chan(chan_mask_i, 4'd0);
          scan_mask_d = chan_mask_i;
          addr_d      = nxt[2:0];
          set_cnt_d   = 4'd0;
          state_d     = SETTLE;
        end
      end
      SETTLE: begin
        if (set_cnt_q == 4'(ADDR_SETTLE - 1)) state_d = START;
        else set_cnt_d = set_cnt_q + 4'd1;
      end
      START: begin
        tmo_d   = '0;
        state_d = CONVERT;
      end
      CONVERT: begin
        if (conv_done_i) wr = 1'b1;
        else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) to_hit = 1'b1;
        else tmo_d = tmo_q + TW'(1);
        if (wr || to_hit) begin
          // A dropped enable lets the current conversion finish but stops the walk.
          nxt = next_chan(scan_mask_q, {1'b0, addr_q} + 4'd1);
          if (enable_i && nxt[3]) begin
            addr_d    = nxt[2:0];
            set_cnt_d = 4'd0;
            state_d   = SETTLE;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    tx_valid_d = tx_valid_q;
    tx_data_d  = tx_data_q;
    if (wr) begin
      tx_valid_d = 1'b1;
      tx_data_d  = {addr_q, conv_data_i};
    end else if (tx_valid_q && tx_ready_i) begin
      tx_valid_d = 1'b0;
    end
    // Newly raised flags take priority over a same-cycle clear.
    status_d = clear_status_i ? 3'b000 : status_q;
    status_d = status_d | {to_hit, tick && (state_q != IDLE), wr && tx_valid_q && !tx_ready_i};
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      per_cnt_q   <= '0;
      tmo_q       <= '0;
      set_cnt_q   <= '0;
      scan_mask_q <= '0;
      addr_q      <= '0;
      tx_valid_q  <= 1'b0;
      tx_data_q   <= '0;
      status_q    <= '0;
    end else begin
      state_q     <= state_d;
      per_cnt_q   <= per_cnt_d;
      tmo_q       <= tmo_d;
      set_cnt_q   <= set_cnt_d;
      scan_mask_q <= scan_mask_d;
      addr_q      <= addr_d;
      tx_valid_q  <= tx_valid_d;
      tx_data_q   <= tx_data_d;
      status_q    <= status_d;
    end
  end

  assign conv_addr_o  = addr_q;
  assign conv_start_o = (state_q == START);
  assign busy_o       = (state_q != IDLE);
  assign tx_valid_o   = tx_valid_q;
  assign tx_data_o    = tx_data_q;
  assign status_o     = status_q;

endmodule
